// File: rtl/regfile_scoreboard.sv
// RAW-hazard scoreboard for the RV32I register file: per-register pending-write
// counters, decode stall generation and pending-write overflow protection.
module regfile_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit BYPASS_WB = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic        rs1_used_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rd_i,
  input  logic        rd_wr_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        issue_accept_o,
  output logic [31:0] busy_o,
  output logic [7:0]  inflight_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt [32];
  logic [7:0]       r_inflight;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd, w_cnt_wb;
  logic             w_drain1, w_drain2, w_h1, w_h2, w_hsat;
  logic             w_stall, w_accept, w_inc, w_dec, w_same, w_err_set;
  logic [31:0]      w_busy;

  assign w_cnt_rs1 = r_cnt[rs1_i];
  assign w_cnt_rs2 = r_cnt[rs2_i];
  assign w_cnt_rd  = r_cnt[rd_i];
  assign w_cnt_wb  = r_cnt[wb_rd_i];

  // A writeback retiring the last pending write only clears the hazard when forwarded.
  assign w_drain1 = BYPASS_WB && wb_valid_i && (wb_rd_i == rs1_i) && (w_cnt_rs1 == CNT_ONE);
  assign w_drain2 = BYPASS_WB && wb_valid_i && (wb_rd_i == rs2_i) && (w_cnt_rs2 == CNT_ONE);

  assign w_h1   = rs1_used_i && (rs1_i != 5'd0) && (w_cnt_rs1 != CNT_ZERO) && !w_drain1;
  assign w_h2   = rs2_used_i && (rs2_i != 5'd0) && (w_cnt_rs2 != CNT_ZERO) && !w_drain2;
  assign w_hsat = rd_wr_i && (rd_i != 5'd0) && (w_cnt_rd == CNT_MAX)
                  && !(wb_valid_i && (wb_rd_i == rd_i));

  assign w_stall   = issue_valid_i && !flush_i && (w_h1 || w_h2 || w_hsat);
  assign w_accept  = issue_valid_i && !flush_i && !w_stall;
  assign w_inc     = w_accept && rd_wr_i && (rd_i != 5'd0);
  assign w_dec     = wb_valid_i && (wb_rd_i != 5'd0) && (w_cnt_wb != CNT_ZERO);
  assign w_same    = w_inc && w_dec && (rd_i == wb_rd_i);
  assign w_err_set = wb_valid_i && (wb_rd_i != 5'd0) && (w_cnt_wb == CNT_ZERO);

  // Busy vector derived from counter state; x0 is never tracked.
  always_comb begin
    w_busy = 32'd0;
    for (int i = 1; i < 32; i++) begin
      w_busy[i] = (r_cnt[i] != CNT_ZERO);
    end
  end

  // Counter, in-flight total and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_inflight <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (flush_i) begin
        for (int i = 0; i < 32; i++) begin
          r_cnt[i] <= CNT_ZERO;
        end
        r_inflight <= 8'd0;
      end else begin
        if (w_inc && !w_same) begin
          r_cnt[rd_i] <= w_cnt_rd + CNT_ONE;
        end
        if (w_dec && !w_same) begin
          r_cnt[wb_rd_i] <= w_cnt_wb - CNT_ONE;
        end
        if (w_inc && !w_dec) begin
          r_inflight <= r_inflight + 8'd1;
        end else if (w_dec && !w_inc) begin
          r_inflight <= r_inflight - 8'd1;
        end
      end
    end
  end

  assign stall_o        = w_stall;
  assign issue_accept_o = w_accept;
  assign busy_o         = w_busy;
  assign inflight_o     = r_inflight;
  assign err_o          = r_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a random
// run against a pending-write-count reference model.
module tb_regfile_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid, rs1_used, rs2_used, rd_wr, wb_valid, flush;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        stall, accept, err;
  logic [31:0] busy;
  logic [7:0]  inflight;
  logic        stall_b, accept_b, err_b;
  logic [31:0] busy_b;
  logic [7:0]  inflight_b;

  int n_pass  = 0;
  int n_total = 0;
  int mdl_cnt [32];
  bit mdl_err;

  always #5 clk = ~clk;

  regfile_scoreboard #(.CNT_W(2), .BYPASS_WB(1'b0)) dut (
    .clk(clk), .rst(rst), .issue_valid_i(issue_valid), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_i(rd), .rd_wr_i(rd_wr),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush), .stall_o(stall),
    .issue_accept_o(accept), .busy_o(busy), .inflight_o(inflight), .err_o(err));

  regfile_scoreboard #(.CNT_W(2), .BYPASS_WB(1'b1)) dut_byp (
    .clk(clk), .rst(rst), .issue_valid_i(issue_valid), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_i(rd), .rd_wr_i(rd_wr),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush), .stall_o(stall_b),
    .issue_accept_o(accept_b), .busy_o(busy_b), .inflight_o(inflight_b), .err_o(err_b));

  task automatic clear_inputs();
    issue_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd = 5'd0; rd_wr = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue_rd(input logic [4:0] r);
    @(negedge clk);
    clear_inputs();
    issue_valid = 1'b1; rd = r; rd_wr = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (busy !== 32'd0) $display("FAIL reset_busy got %h exp 0", busy); else n_pass++;
    n_total++; if (inflight !== 8'd0) $display("FAIL reset_inflight got %0d exp 0", inflight); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    n_total++; if ({stall, accept} !== 2'b00) $display("FAIL reset_idle_outs got %b exp 00", {stall, accept}); else n_pass++;
    @(negedge clk);
    issue_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6; rs1_used = 1'b1; rs2_used = 1'b1;
    #1;
    n_total++; if ({stall, accept} !== 2'b01) $display("FAIL reset_first_issue got %b exp 01", {stall, accept}); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_raw();
    do_reset();
    issue_rd(5'd5);
    n_total++; if (busy[5] !== 1'b1 || inflight !== 8'd1) $display("FAIL raw_issue busy5 %b inflight %0d exp 1/1", busy[5], inflight); else n_pass++;
    @(negedge clk);
    issue_valid = 1'b1; rs1 = 5'd5; rs1_used = 1'b1;
    #1;
    n_total++; if ({stall, stall_b} !== 2'b11) $display("FAIL raw_stall got %b exp 11", {stall, stall_b}); else n_pass++;
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    n_total++; if ({stall, accept} !== 2'b10) $display("FAIL raw_wb_nobypass got %b exp 10", {stall, accept}); else n_pass++;
    n_total++; if ({stall_b, accept_b} !== 2'b01) $display("FAIL raw_wb_bypass got %b exp 01", {stall_b, accept_b}); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (busy[5] !== 1'b0 || inflight !== 8'd0) $display("FAIL raw_drained busy5 %b inflight %0d exp 0/0", busy[5], inflight); else n_pass++;
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    n_total++; if ({stall, accept} !== 2'b01) $display("FAIL raw_retry got %b exp 01", {stall, accept}); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 3; k++) issue_rd(5'd7);
    n_total++; if (inflight !== 8'd3) $display("FAIL sat_count got %0d exp 3", inflight); else n_pass++;
    @(negedge clk);
    issue_valid = 1'b1; rd = 5'd7; rd_wr = 1'b1;
    #1;
    n_total++; if ({stall, accept} !== 2'b10) $display("FAIL sat_stall got %b exp 10", {stall, accept}); else n_pass++;
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1;
    n_total++; if ({stall, accept} !== 2'b01) $display("FAIL sat_wb_accept got %b exp 01", {stall, accept}); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (inflight !== 8'd3 || busy !== 32'h0000_0080) $display("FAIL sat_hold inflight %0d busy %h exp 3/00000080", inflight, busy); else n_pass++;
    wb_valid = 1'b0;
    #1;
    n_total++; if (stall !== 1'b1) $display("FAIL sat_still_full got %b exp 1", stall); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_x0_err();
    do_reset();
    @(negedge clk);
    issue_valid = 1'b1; rd = 5'd0; rd_wr = 1'b1; wb_valid = 1'b1; wb_rd = 5'd0;
    @(posedge clk);
    #1;
    n_total++; if (busy !== 32'd0 || inflight !== 8'd0 || err !== 1'b0) $display("FAIL x0_ignored busy %h inflight %0d err %b exp 0/0/0", busy, inflight, err); else n_pass++;
    clear_inputs();
    wb_valid = 1'b1; wb_rd = 5'd9;
    #1;
    n_total++; if (err !== 1'b0) $display("FAIL err_not_early got %b exp 0", err); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (err !== 1'b1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
    clear_inputs();
    flush = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    @(posedge clk);
    #1;
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got %b exp 1", err); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    issue_rd(5'd3);
    issue_rd(5'd3);
    issue_rd(5'd4);
    n_total++; if (inflight !== 8'd3 || busy !== 32'h0000_0018) $display("FAIL flush_setup inflight %0d busy %h exp 3/00000018", inflight, busy); else n_pass++;
    @(negedge clk);
    issue_valid = 1'b1; rd = 5'd3; rd_wr = 1'b1; flush = 1'b1;
    #1;
    n_total++; if ({stall, accept} !== 2'b00) $display("FAIL flush_block got %b exp 00", {stall, accept}); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (busy !== 32'd0 || inflight !== 8'd0) $display("FAIL flush_clear busy %h inflight %0d exp 0/0", busy, inflight); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 4; k++) issue_rd(5'(k));
    n_total++; if (inflight !== 8'd4) $display("FAIL areset_setup got %0d exp 4", inflight); else n_pass++;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 32'd0 || inflight !== 8'd0) $display("FAIL areset_immediate busy %h inflight %0d exp 0/0", busy, inflight); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit          h1, h2, hsat, exp_stall, exp_acc, dec_ok;
    logic [31:0] exp_busy;
    int          exp_infl;
    do_reset();
    for (int i = 0; i < 32; i++) mdl_cnt[i] = 0;
    mdl_err = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      issue_valid = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom_range(0, 1)); rs2_used = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 7)); rd_wr = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      wb_rd = 5'($urandom_range(0, 7));
      wb_valid = ($urandom_range(0, 1) == 1) && (mdl_cnt[wb_rd] != 0 || $urandom_range(0, 39) == 0) && !flush;
      #1;
      h1   = rs1_used && rs1 != 0 && mdl_cnt[rs1] > 0;
      h2   = rs2_used && rs2 != 0 && mdl_cnt[rs2] > 0;
      hsat = rd_wr && rd != 0 && mdl_cnt[rd] == MAXC && !(wb_valid && wb_rd == rd);
      exp_stall = issue_valid && !flush && (h1 || h2 || hsat);
      exp_acc   = issue_valid && !flush && !exp_stall;
      n_total++; if (stall !== exp_stall) $display("FAIL rand_stall cyc %0d got %b exp %b", cyc, stall, exp_stall); else n_pass++;
      n_total++; if (accept !== exp_acc) $display("FAIL rand_accept cyc %0d got %b exp %b", cyc, accept, exp_acc); else n_pass++;
      @(posedge clk);
      if (flush) begin
        for (int i = 0; i < 32; i++) mdl_cnt[i] = 0;
      end else begin
        dec_ok = wb_valid && wb_rd != 0 && mdl_cnt[wb_rd] > 0;
        if (wb_valid && wb_rd != 0 && mdl_cnt[wb_rd] == 0) mdl_err = 1'b1;
        if (dec_ok) mdl_cnt[wb_rd] = mdl_cnt[wb_rd] - 1;
        if (exp_acc && rd_wr && rd != 0) mdl_cnt[rd] = mdl_cnt[rd] + 1;
      end
      exp_busy = 32'd0;
      exp_infl = 0;
      for (int i = 1; i < 32; i++) begin
        exp_busy[i] = (mdl_cnt[i] > 0);
        exp_infl += mdl_cnt[i];
      end
      #1;
      n_total++; if (busy !== exp_busy) $display("FAIL rand_busy cyc %0d got %h exp %h", cyc, busy, exp_busy); else n_pass++;
      n_total++; if (inflight !== 8'(exp_infl)) $display("FAIL rand_inflight cyc %0d got %0d exp %0d", cyc, inflight, exp_infl); else n_pass++;
      n_total++; if (err !== mdl_err) $display("FAIL rand_err cyc %0d got %b exp %b", cyc, err, mdl_err); else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    test_reset();
    test_raw();
    test_saturation();
    test_x0_err();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Tracks outstanding (issued, not yet written back) writes to each of the 32 architectural registers of the RV32I register file.
- Sits between decode/issue and writeback and produces the decode stall that protects register-file reads from RAW hazards.
- Also protects per-register pending-write counters from overflow.
- x0 is never tracked; it is hardwired zero in the register file.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2^CNT_W - 1.
- BYPASS_WB, 0, 1 = a same-cycle writeback that drains a register's last pending write clears that register's RAW hazard (datapath forwards datawb); 0 = it does not.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- issue_valid_i  input  1  decode presents an instruction this cycle
- rs1_i  input  5  source register 1 address
- rs2_i  input  5  source register 2 address
- rs1_used_i  input  1  instruction reads rs1
- rs2_used_i  input  1  instruction reads rs2
- rd_i  input  5  destination register address
- rd_wr_i  input  1  instruction writes rd (regwren at writeback)
- wb_valid_i  input  1  writeback commits a register write this cycle
- wb_rd_i  input  5  writeback destination address
- flush_i  input  1  pipeline flush; discards all pending writes
- stall_o  output  1  hold decode; instruction not accepted
- issue_accept_o  output  1  instruction accepted this cycle
- busy_o  output  32  bit i = register i has at least one pending write; bit 0 always 0
- inflight_o  output  8  total pending writes across all registers
- err_o  output  1  sticky: writeback retired a register with zero pending writes

Behaviour:
- Reset (async assert, sync-safe deassert handled at top): all counters 0, busy_o = 0, inflight_o = 0, err_o = 0. stall_o and issue_accept_o are combinational and read 0 while issue_valid_i = 0.
- Hazard terms (combinational, same cycle):
  - h1 = rs1_used_i && rs1_i != 0 && cnt[rs1_i] != 0 && !drain1.
  - drain1 = BYPASS_WB && wb_valid_i && wb_rd_i == rs1_i && cnt[rs1_i] == 1.
  - h2 is the same for rs2.
  - hsat = rd_wr_i && rd_i != 0 && cnt[rd_i] == max && !(wb_valid_i && wb_rd_i == rd_i).
- stall_o = issue_valid_i && !flush_i && (h1 || h2 || hsat).
- issue_accept_o = issue_valid_i && !flush_i && !stall_o.
- inc = issue_accept_o && rd_wr_i && rd_i != 0.
- dec = wb_valid_i && wb_rd_i != 0 && cnt[wb_rd_i] != 0.
- Counter update at posedge clk, with priority:
  - flush_i: all counters cleared, inflight_o cleared; issue and writeback in that cycle are ignored for counting. err_o is not cleared.
  - else, inc and dec on the same register: counter unchanged.
  - else, inc: +1 on rd_i. dec: -1 on wb_rd_i. Both may occur on different registers in the same cycle.
- inflight_o tracks inc - dec, so the net change is -1, 0 or +1 per cycle. It equals the sum of all counters (max 31 * (2^CNT_W - 1)).
- wb_valid_i with wb_rd_i != 0 and cnt[wb_rd_i] == 0: no counter change; err_o set at the next edge and held until rst.
- wb_rd_i == 0 or rd_i == 0: never counted, never an error.
- BYPASS_WB = 0: a writeback draining rs1/rs2 still stalls in that cycle. The register file write lands at the edge, so the instruction issues the following cycle (1-cycle penalty).
- No latency on stall: a stall is a pure function of current inputs and counter state.
- Mid-operation reset: all state discarded immediately regardless of in-flight writes.

Test Plan:
- Reset then idle: after rst, busy_o = 0, inflight_o = 0, err_o = 0. issue_valid_i = 1 with rs1 = 5, rs2 = 6 unused-rd -> stall_o = 0, issue_accept_o = 1.
- RAW stall: issue rd = 5 (accepted, busy_o[5] = 1, inflight_o = 1). Next cycle issue rs1 = 5 -> stall_o = 1. wb_rd_i = 5 that cycle -> with BYPASS_WB = 0 stall_o stays 1, and next cycle stall_o = 0 with busy_o[5] = 0. With BYPASS_WB = 1, stall_o = 0 in the writeback cycle.
- Saturation (CNT_W = 2): three accepted issues to rd = 7 -> cnt = 3, inflight_o = 3. A fourth issue to rd = 7 -> stall_o = 1. The same issue with wb_rd_i = 7 in that cycle -> accepted, cnt stays 3.
- x0 and error: issue rd = 0 and wb_rd_i = 0 -> no change, err_o = 0. wb_rd_i = 9 with cnt[9] = 0 -> err_o = 1 next cycle and stays 1 through later flush_i.
- Flush priority: cnt[3] = 2, cnt[4] = 1. flush_i = 1 with simultaneous issue rd = 3 -> issue_accept_o = 0. Next cycle busy_o = 0, inflight_o = 0.
- Async reset mid-flight: with inflight_o = 4, assert rst between clock edges -> busy_o and inflight_o go to 0 immediately, before the next posedge.
